// File: rtl/morse_key_timer.sv
// Single-key Morse front end: synchronizes and debounces a telegraph key, then
// classifies each press as a dot or dash and signals character completion after a long gap.
module morse_key_timer #(
  parameter int DEB_CYCLES  = 16,
  parameter int DASH_CYCLES = 200,
  parameter int GAP_CYCLES  = 600,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       btn_dot,
  output logic       btn_dash,
  output logic       btn_enter,
  output logic       key_deb,
  output logic [2:0] sym_cnt,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_MAX  = CNT_W'(DASH_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       SYM_MAX   = 3'd5;

  logic             key_m;
  logic             key_s;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] press_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [1:0]       state;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
    end
  end

  // key_deb only follows key_s after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      key_deb <= 1'b0;
    end else if (key_s == key_deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      key_deb <= ~key_deb;
    end else begin
      deb_cnt <= deb_cnt + CNT_ONE;
    end
  end

  // key_deb is only high in IDLE/GAP on a rise, so a level test doubles as edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      press_cnt <= '0;
      gap_cnt   <= '0;
      sym_cnt   <= 3'd0;
      btn_dot   <= 1'b0;
      btn_dash  <= 1'b0;
      btn_enter <= 1'b0;
    end else begin
      btn_dot   <= 1'b0;
      btn_dash  <= 1'b0;
      btn_enter <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_deb) begin
            state     <= S_PRESS;
            press_cnt <= '0;
          end
        end
        S_PRESS: begin
          if (!key_deb) begin
            if (sym_cnt != SYM_MAX) begin
              if (press_cnt >= DASH_MAX) btn_dash <= 1'b1;
              else                       btn_dot  <= 1'b1;
              sym_cnt <= sym_cnt + 3'd1;
            end
            state   <= S_GAP;
            gap_cnt <= '0;
          end else if (press_cnt != DASH_MAX) begin
            press_cnt <= press_cnt + CNT_ONE;
          end
        end
        S_GAP: begin
          // A new press beats gap expiry in the same cycle.
          if (key_deb) begin
            state     <= S_PRESS;
            press_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            btn_enter <= (sym_cnt != 3'd0);
            sym_cnt   <= 3'd0;
            state     <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
